// File: rtl/temp_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : temp_seg_display
// Brief    : Converts a 14-bit temperature magnitude (0.01 C/LSB) to BCD with
//            an iterative double-dabble engine and drives a 6-digit
//            multiplexed common-anode 7-segment display as "[-]HTU.th".
//            Optional: define SEG_DEGHOST_EN to blank sel for the first 16
//            cycles of every digit slot.
// Revision : 1.0 - initial release
// ============================================================================
module temp_seg_display #(
  parameter logic [15:0] SCAN_CNT  = 16'd49_999,
  parameter logic [13:0] ERR_LIMIT = 14'd12500
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] temp_data_r,
  input  logic        temp_sign,
  input  logic        temp_over,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        busy
);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_ERR   = 8'h86;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        over_d;
  logic        start;
  logic        pending;
  logic        capture;
  logic [3:0]  bit_cnt;
  logic [19:0] bcd;
  logic [19:0] bcd_adj;
  logic [13:0] bin;
  logic [13:0] mag;
  logic        sign;
  logic [7:0]  disp [0:5];
  logic [15:0] scan_cnt;
  logic [2:0]  slot;
  logic [5:0]  sel_nxt;

  // Map one BCD digit to its active-low segment code (dp off)
  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    logic [7:0] code;
    case (d)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Rising edge of the strobe level; a held-high level yields one event
  assign start   = temp_over & ~over_d;
  assign capture = (state == ST_IDLE) && (start || pending);
  assign busy    = (state != ST_IDLE);

  // Add-3 correction for every BCD nibble that is 5 or more
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd[4*gi +: 4] >= 4'd5) ? (bcd[4*gi +: 4] + 4'd3)
                                                           : bcd[4*gi +: 4];
    end
  endgenerate

  // Strobe delay register and conversion state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      over_d <= 1'b0;
      state  <= ST_IDLE;
    end else begin
      over_d <= temp_over;
      state  <= state_nxt;
    end
  end

  // Next-state logic: capture -> 14 shifts -> latch result -> idle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start || pending) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == 4'd13) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // One-deep request queue: an event seen while busy is replayed after DONE
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pending <= 1'b0;
    end else if (state != ST_IDLE) begin
      if (start) pending <= 1'b1;
    end else if (capture) begin
      pending <= 1'b0;
    end
  end

  // Double-dabble datapath and digit register update
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt <= 4'd0;
      bcd     <= 20'd0;
      bin     <= 14'd0;
      mag     <= 14'd0;
      sign    <= 1'b0;
      for (int i = 0; i < 6; i++) disp[i] <= SEG_BLANK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (capture) begin
            bin     <= temp_data_r;
            mag     <= temp_data_r;
            sign    <= temp_sign;
            bcd     <= 20'd0;
            bit_cnt <= 4'd0;
          end
        end
        ST_SHIFT: begin
          {bcd, bin} <= {bcd_adj[18:0], bin, 1'b0};
          bit_cnt    <= bit_cnt + 4'd1;
        end
        ST_DONE: begin
          if (mag > ERR_LIMIT) begin
            disp[5] <= SEG_BLANK;
            for (int i = 0; i < 5; i++) disp[i] <= SEG_ERR;
          end else begin
            // "-0.00" is suppressed: minus only for a non-zero magnitude
            disp[5] <= (sign && (mag != 14'd0)) ? SEG_MINUS : SEG_BLANK;
            disp[4] <= (bcd[19:16] == 4'd0) ? SEG_BLANK : digit_seg(bcd[19:16]);
            disp[3] <= (bcd[19:12] == 8'd0) ? SEG_BLANK : digit_seg(bcd[15:12]);
            disp[2] <= digit_seg(bcd[11:8]) & 8'h7F;
            disp[1] <= digit_seg(bcd[7:4]);
            disp[0] <= digit_seg(bcd[3:0]);
          end
        end
        default: ;
      endcase
    end
  end

  // Slot timer: counter wraps at SCAN_CNT and advances the slot index 0..5
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt <= 16'd0;
      slot     <= 3'd0;
    end else if (scan_cnt == SCAN_CNT) begin
      scan_cnt <= 16'd0;
      slot     <= (slot == 3'd5) ? 3'd0 : (slot + 3'd1);
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // Digit select for the current slot, optionally blanked at slot start
  always_comb begin
    sel_nxt = ~(6'b000001 << slot);
`ifdef SEG_DEGHOST_EN
    if (scan_cnt < 16'd16) sel_nxt = 6'b111111;
`endif
  end

  // Registered display outputs; sel and seg move together
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel <= 6'b111111;
      seg <= SEG_BLANK;
    end else begin
      sel <= sel_nxt;
      seg <= disp[slot];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_temp_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_temp_seg_display
// Brief    : Self-checking bench for temp_seg_display with a decimal
//            arithmetic reference model of the display contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temp_seg_display;

  localparam logic [15:0] SCAN = 16'd19;
  localparam int          SLOT_LEN = 20;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] data  = 14'd0;
  logic        sgn   = 1'b0;
  logic        over  = 1'b0;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] digit_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  temp_seg_display #(.SCAN_CNT(SCAN), .ERR_LIMIT(14'd12500)) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .temp_data_r(data),
    .temp_sign  (sgn),
    .temp_over  (over),
    .sel        (sel),
    .seg        (seg),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Expected segment code of one slot, from decimal digits of the reading
  function automatic logic [7:0] model_seg(input int slot, input int mag,
                                           input bit neg, input bit blank);
    int d4, d3, d2, d1, d0;
    if (blank) return 8'hFF;
    if (mag > 12500) return (slot == 5) ? 8'hFF : 8'h86;
    d4 = mag / 10000;
    d3 = (mag / 1000) % 10;
    d2 = (mag / 100) % 10;
    d1 = (mag / 10) % 10;
    d0 = mag % 10;
    case (slot)
      5: return (neg && mag != 0) ? 8'hBF : 8'hFF;
      4: return (d4 == 0) ? 8'hFF : digit_tab[d4];
      3: return (mag < 1000) ? 8'hFF : digit_tab[d3];
      2: return digit_tab[d2] & 8'h7F;
      1: return digit_tab[d1];
      default: return digit_tab[d0];
    endcase
  endfunction

  // Scan every slot once and compare its segment code with the model
  task automatic check_display(input int mag, input bit neg, input bit blank,
                               input string name);
    for (int k = 5; k >= 0; k--) begin
      logic [5:0] want_sel;
      logic [7:0] want_seg;
      bit found;
      int t;
      want_sel = ~(6'b000001 << k);
      want_seg = model_seg(k, mag, neg, blank);
      found = 0;
      t = 0;
      while (t < 300 && !found) begin
        @(negedge clk);
        t++;
        if (sel === want_sel) found = 1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL %s slot%0d: sel never showed %b (last %b)", name, k, want_sel, sel);
      end else if (seg !== want_seg) begin
        errors++;
        $display("FAIL %s slot%0d seg: got %h expected %h (mag=%0d neg=%0d)",
                 name, k, seg, want_seg, mag, neg);
      end
    end
  endtask

  // Raise the strobe for 'hold' cycles, check busy profile, then the display
  task automatic run_conv(input int mag, input bit neg, input int hold, input string name);
    int first, last, cnt, rises;
    bit prev;
    @(negedge clk);
    data = 14'(mag);
    sgn  = neg;
    over = 1'b1;
    first = -1; last = -1; cnt = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
        if (!prev) rises++;
      end
      prev = (busy === 1'b1);
      if (i + 1 >= hold) over = 1'b0;
    end
    checks++;
    if (first != 0 || last != 14 || cnt != 15 || rises != 1) begin
      errors++;
      $display("FAIL %s busy: first=%0d last=%0d count=%0d conversions=%0d, expected 0/14/15/1",
               name, first, last, cnt, rises);
    end
    check_display(mag, neg, 1'b0, name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sel !== 6'h3F || seg !== 8'hFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: sel=%b seg=%h busy=%b, expected 111111/ff/0", sel, seg, busy);
    end
    rst_n = 1'b1;
    repeat (37) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sel !== 6'h3F || seg !== 8'hFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: sel=%b seg=%h busy=%b, expected 111111/ff/0", sel, seg, busy);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (sel !== 6'h3F || seg !== 8'hFF || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: sel=%b seg=%h busy=%b, expected 111111/ff/0", sel, seg, busy);
      end
    end
    rst_n = 1'b1;
  endtask

  // Must start right at the negedge where reset was released
  task automatic test_scan();
    for (int n = 1; n <= 6 * SLOT_LEN + 10; n++) begin
      int cnt, slot;
      logic [5:0] exp_sel;
      @(negedge clk);
      cnt  = (n - 1) % SLOT_LEN;
      slot = ((n - 1) / SLOT_LEN) % 6;
      exp_sel = ~(6'b000001 << slot);
`ifdef SEG_DEGHOST_EN
      if (cnt < 16) exp_sel = 6'b111111;
`endif
      checks++;
      if (sel !== exp_sel || seg !== 8'hFF) begin
        errors++;
        $display("FAIL scan n=%0d cnt=%0d: sel=%b seg=%h, expected %b/ff",
                 n, cnt, sel, seg, exp_sel);
      end
    end
  endtask

  task automatic test_directed();
    run_conv(12500, 1'b0, 50, "hold_12500");
    run_conv(2506,  1'b0, 3,  "conv_2506");
    run_conv(5,     1'b0, 1,  "conv_5");
    run_conv(0,     1'b1, 2,  "conv_neg0");
    run_conv(1000,  1'b1, 4,  "conv_neg1000");
    run_conv(13000, 1'b0, 2,  "conv_err13000");
    run_conv(12501, 1'b1, 2,  "conv_err12501");
    run_conv(16383, 1'b0, 2,  "conv_max");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    data = 14'd12500;
    sgn  = 1'b0;
    over = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bit exp_busy;
      @(negedge clk);
      exp_busy = (i <= 14) || (i >= 16 && i <= 30);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL b2b busy after C%0d: got %b expected %b", i, busy, exp_busy);
      end
      case (i)
        1:  over = 1'b0;
        3:  begin over = 1'b1; data = 14'd2506; end
        5:  over = 1'b0;
        7:  over = 1'b1;
        10: over = 1'b0;
        default: ;
      endcase
    end
    check_display(2506, 1'b0, 1'b0, "b2b_result");
  endtask

  task automatic test_random();
    for (int r = 0; r < 14; r++) begin
      int  mag;
      bit  neg;
      int  hold;
      mag  = (r % 4 == 3) ? int'($urandom_range(12490, 12510)) : int'($urandom_range(0, 16383));
      neg  = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 30));
      run_conv(mag, neg, hold, "random");
    end
  endtask

  task automatic test_reset_mid_conv();
    @(negedge clk);
    data = 14'd9876;
    sgn  = 1'b1;
    over = 1'b1;
    repeat (6) @(negedge clk);
    over  = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel !== 6'h3F || seg !== 8'hFF || busy !== 1'b0) begin
      errors++;
      $display("FAIL midconv_reset: sel=%b seg=%h busy=%b, expected 111111/ff/0", sel, seg, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midconv_busy: got %b expected 0", busy);
    end
    check_display(0, 1'b0, 1'b1, "midconv_blank");
  endtask

  initial begin
    test_reset();
    test_scan();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid_conv();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/temp_seg_display.md
Name: temp_seg_display

Overview:
Consumes the DS18B20 controller's outputs: magnitude in 0.01 °C units, sign, and the update strobe. On each new reading it converts the 14-bit binary magnitude to five BCD digits with an iterative shift-add-3 (double-dabble) engine. It drives a 6-digit multiplexed common-anode 7-segment display showing "[-]HTU.th", with leading-zero blanking.

Parameters:
SCAN_CNT, 16'd49_999, sys_clk cycles per digit slot minus 1 (1 ms at 50 MHz)
ERR_LIMIT, 14'd12500, largest valid magnitude; anything above it is shown as an error

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst_n  input  1  asynchronous reset, active low
temp_data_r  input  14  temperature magnitude, 0.01 °C per LSB (0..16383)
temp_sign  input  1  1 = negative temperature
temp_over  input  1  new-reading strobe; a level that may stay high for many sys_clk cycles
sel  output  6  digit select, active low, one-hot-low; sel[5] = leftmost (sign), sel[0] = hundredths
seg  output  8  segments, active low; seg[7] = dp, seg[6:0] = g..a
busy  output  1  conversion in progress

Behaviour:
- Clock and reset: single clock sys_clk. Reset is asynchronous and active-low on sys_rst_n.
- Reset values: sel=6'b111111, seg=8'hFF, busy=0. The digit registers reset to blank, the scan counter and slot index to 0, and the pending flag to 0.
- Strobe detection: temp_over is registered once. A start event is temp_over==1 with the registered copy ==0, i.e. rising edge only; a held-high level produces exactly one event.
- Capture edge (C0): on the edge where a start event is seen in IDLE, capture temp_data_r and temp_sign, clear the BCD register (20 bits), go to SHIFT, busy=1.
- SHIFT state, 14 cycles: on each edge, first add 3 to every BCD nibble that is >=5, then shift {bcd, bin} left by 1. Bit 13 is shifted first.
- DONE state, edge C15: latch the digit registers from the BCD result and the captured sign, then return to IDLE. busy=0 from edge C15 onward.
- Total latency: digit registers change exactly 15 sys_clk edges after the capture edge.
- Start event while busy: set a one-deep pending flag and keep only that event. After DONE, begin a new capture next cycle using the then-current inputs. Further events while pending are absorbed.
- Digit mapping (BCD d4..d0):
  - slot5 = sign
  - slot4 = d4 (hundreds)
  - slot3 = d3 (tens)
  - slot2 = d2 (units), with dp on
  - slot1 = d1 (tenths)
  - slot0 = d0 (hundredths)
- Leading-zero blanking: blank d4 if it is 0. Blank d3 if both d4 and d3 are 0. Units, tenths and hundredths are always shown.
- Sign slot: shows '-' (8'hBF) if the captured sign is 1 and the magnitude is non-zero, otherwise blank. "-0.00" is never displayed.
- Error: if the captured magnitude > ERR_LIMIT, slots 4..0 show 'E' (8'h86), slot2 with dp off, and slot5 is blank.
- Segment codes, dp off:
  - digits: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90
  - blank=FF, '-'=BF, 'E'=86
  - dp on clears bit7 (e.g. 5. = 8'h12).
- Scan:
  - The counter counts 0..SCAN_CNT, then wraps. At wrap the slot index advances 0→1→…→5→0.
  - sel and seg are registered and change together one edge after the index change.
  - Scanning starts right after reset; before the first conversion seg=FF in every slot.
- Reset mid-conversion: abort immediately to the reset values. The previous display content is lost (blank).

Optional Feature:
SEG_DEGHOST_EN. When defined, sel is forced to 6'b111111 for the first 16 sys_clk cycles of every slot (scan counter 0..15); seg is unaffected. SCAN_CNT must be >=16. When undefined, sel is valid for the entire slot.

Test Plan:
- Reset asserted mid-scan → sel=111111, seg=FF, busy=0 while low. After release, sel cycles 111110, 111101, … with seg=FF.
- temp_data_r=12500, sign 0, temp_over high 50 cycles → busy high for 15 cycles, one conversion only. Slots 5..0 seg: FF, F9, A4, 12, C0, C0.
- 2506, sign 0 → FF, FF, A4, 12, C0, 82. 5, sign 0 → FF, FF, FF, 40, C0, 92. 0, sign 1 → FF, FF, FF, 40, C0, C0 (no '-').
- 1000, sign 1 → BF, FF, F9, 40, C0, C0. 13000, sign 0 → FF, 86, 86, 86, 86, 86.
- Second temp_over edge 5 cycles after the first (value changed to 2506) → first result displayed at C15. The second capture starts at C16, and 2506 is displayed at C31.
- SCAN_CNT=19, SEG_DEGHOST_EN defined → per slot, sel=111111 for 16 cycles, then the one-hot-low value for 4 cycles. Undefined → one-hot-low for all 20 cycles.
